// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge-detection stage: FSM states,
// kernel weights, default frame geometry and a small widening helper.
package sobel_pkg;

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH  = 720;
   localparam int DEFAULT_HEIGHT = 540;
   localparam int PIX_W          = 8;
   localparam int GRAD_W         = 11;

   // Sobel weights: outer taps count once, the middle tap of a row/column twice.
   localparam logic signed [GRAD_W-1:0] K_SIDE = 11'sd1;
   localparam logic signed [GRAD_W-1:0] K_MID  = 11'sd2;

   // Zero-extend a pixel into the signed gradient domain.
   function automatic logic signed [GRAD_W-1:0] widen(input logic [PIX_W-1:0] p);
      return {3'b000, p};
   endfunction

endpackage

// File: rtl/sobel_if.sv
// FIFO-side signals of the Sobel stage. The master side is the Sobel block
// (pops the input FIFO, pushes the output FIFO); the slave side is the FIFOs.
interface sobel_if
   import sobel_pkg::*;
#(
   parameter int DW = PIX_W
);
   logic          fifo_in_rd_en;
   logic [DW-1:0] fifo_in_dout;
   logic          fifo_in_empty;
   logic          fifo_out_wr_en;
   logic [DW-1:0] fifo_out_din;
   logic          fifo_out_full;

   modport master (
      output fifo_in_rd_en,
      input  fifo_in_dout,
      input  fifo_in_empty,
      output fifo_out_wr_en,
      output fifo_out_din,
      input  fifo_out_full
   );

   modport slave (
      input  fifo_in_rd_en,
      output fifo_in_dout,
      output fifo_in_empty,
      input  fifo_out_wr_en,
      input  fifo_out_din,
      output fifo_out_full
   );
endinterface

// File: rtl/sobel_window.sv
// Sliding window of two full image lines plus three pixels. Newest pixel
// lands at index 0; the nine 3x3 taps are exposed as o_taps[row][col] with
// row 0 / column 0 being the oldest.
module sobel_window
   import sobel_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DW    = PIX_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_shiftEn,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_taps [3][3]
);
   localparam int DEPTH = 2*WIDTH + 3;

   logic [DW-1:0] r_shift [DEPTH];

   // Shift one pixel in per enabled cycle; reset clears the whole window.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_shift[i] <= '0;
      end else if (i_shiftEn) begin
         r_shift[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) r_shift[i] <= r_shift[i-1];
      end
   end

   // Map window positions to taps: row r sits (2-r) lines back, column c (2-c) pixels back.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            o_taps[r][c] = r_shift[(2-r)*WIDTH + (2-c)];
         end
      end
   end

endmodule

// File: rtl/sobel.sv
// Sobel gradient-magnitude stage. Pops grayscale pixels in raster order,
// emits one edge pixel per input pixel with a latency of WIDTH+1 pixels,
// forces the frame border to zero and flushes the tail without new input.
module sobel
   import sobel_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int HEIGHT      = DEFAULT_HEIGHT,
   parameter int FIFO_DWIDTH = PIX_W
) (
   input  logic    clock,
   input  logic    reset,
   sobel_if.master fifo
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int COL_W = $clog2(WIDTH);

   localparam logic [CNT_W-1:0] C_TOTAL  = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] C_FILLED = CNT_W'(WIDTH + 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

   state_t                   r_state;
   logic [CNT_W-1:0]         r_inCount;
   logic [ROW_W-1:0]         r_outRow;
   logic [COL_W-1:0]         r_outCol;

   logic                     w_inDone;
   logic                     w_step;
   logic                     w_rdEn;
   logic                     w_shiftEn;
   logic                     w_lastPixel;
   logic                     w_border;
   logic [FIFO_DWIDTH-1:0]   w_winDin;
   logic [FIFO_DWIDTH-1:0]   w_taps [3][3];
   logic signed [GRAD_W-1:0] w_gx;
   logic signed [GRAD_W-1:0] w_gy;
   logic [GRAD_W-1:0]        w_absGx;
   logic [GRAD_W-1:0]        w_absGy;
   logic [GRAD_W-1:0]        w_mag;
   logic [FIFO_DWIDTH-1:0]   w_edge;

   sobel_window #(
      .WIDTH (WIDTH),
      .DW    (FIFO_DWIDTH)
   ) u_window (
      .clock     (clock),
      .reset     (reset),
      .i_shiftEn (w_shiftEn),
      .i_din     (w_winDin),
      .o_taps    (w_taps)
   );

   // Handshake: a RUN step needs output space plus either input or an exhausted frame (flush).
   always_comb begin
      w_inDone    = (r_inCount == C_TOTAL);
      w_step      = reset && (r_state == S_RUN) && !fifo.fifo_out_full &&
                    (!fifo.fifo_in_empty || w_inDone);
      w_rdEn      = reset && (((r_state == S_FILL) && !fifo.fifo_in_empty) ||
                              (w_step && !w_inDone));
      w_shiftEn   = w_rdEn || w_step;
      w_winDin    = w_inDone ? '0 : fifo.fifo_in_dout;
      w_lastPixel = (r_outRow == LAST_ROW) && (r_outCol == LAST_COL);
   end

   // Gradient magnitude of the current window, clamped to a pixel; border positions read zero.
   always_comb begin
      w_gx = K_SIDE * widen(w_taps[0][2]) + K_MID * widen(w_taps[1][2]) + K_SIDE * widen(w_taps[2][2])
           - K_SIDE * widen(w_taps[0][0]) - K_MID * widen(w_taps[1][0]) - K_SIDE * widen(w_taps[2][0]);
      w_gy = K_SIDE * widen(w_taps[2][0]) + K_MID * widen(w_taps[2][1]) + K_SIDE * widen(w_taps[2][2])
           - K_SIDE * widen(w_taps[0][0]) - K_MID * widen(w_taps[0][1]) - K_SIDE * widen(w_taps[0][2]);
      w_absGx  = w_gx[GRAD_W-1] ? -w_gx : w_gx;
      w_absGy  = w_gy[GRAD_W-1] ? -w_gy : w_gy;
      w_mag    = (w_absGx + w_absGy) >> 1;
      w_border = (r_outRow == '0) || (r_outRow == LAST_ROW) ||
                 (r_outCol == '0) || (r_outCol == LAST_COL);
      if (w_border)          w_edge = '0;
      else if (w_mag > 11'd255) w_edge = '1;
      else                   w_edge = w_mag[FIFO_DWIDTH-1:0];
   end

   assign fifo.fifo_in_rd_en  = w_rdEn;
   assign fifo.fifo_out_wr_en = w_step;
   assign fifo.fifo_out_din   = w_step ? w_edge : '0;

   // Frame sequencing: prime the window, then one output per step until the last pixel, then rearm.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= S_FILL;
         r_inCount <= '0;
         r_outRow  <= '0;
         r_outCol  <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_rdEn) begin
                  r_inCount <= r_inCount + 1'b1;
                  if (r_inCount == C_FILLED) r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_step) begin
                  if (w_lastPixel) begin
                     r_state   <= S_FILL;
                     r_inCount <= '0;
                     r_outRow  <= '0;
                     r_outCol  <= '0;
                  end else begin
                     if (!w_inDone) r_inCount <= r_inCount + 1'b1;
                     if (r_outCol == LAST_COL) begin
                        r_outCol <= '0;
                        r_outRow <= r_outRow + 1'b1;
                     end else begin
                        r_outCol <= r_outCol + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel.sv
// Directed bench for the Sobel stage on a 4x4 frame. Input FIFO and output
// FIFO are modelled by the bench; expected pixels come from a direct 2D
// reference and are queued when a frame is loaded, then popped on each push.
module tb_sobel;
   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic clock = 1'b0;
   logic reset = 1'b0;

   sobel_if #(.DW(8)) bus ();

   sobel #(
      .WIDTH       (W),
      .HEIGHT      (H),
      .FIFO_DWIDTH (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .fifo  (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] img [N];
   logic [7:0] inQ [$];
   logic [7:0] expQ [$];

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int rdTotal = 0;
   int wrTotal = 0;
   int sixthRdCycle = -1;
   int firstWrCycle = -1;
   int lastWrF1Cycle = -1;
   int firstRdF2Cycle = -1;
   bit bubbles = 0;
   bit forceFull = 0;

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int px(int r, int c);
      return int'(img[r*W + c]);
   endfunction

   // Reference edge pixel for frame position (r, c) of the current image.
   function automatic logic [7:0] expectedPixel(int r, int c);
      int gx, gy, mag;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
      gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
      gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
      mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
      return (mag > 255) ? 8'd255 : 8'(mag);
   endfunction

   // Queue the current image for input and its reference outputs for checking.
   task automatic applyStimulus();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            inQ.push_back(img[r*W + c]);
            expQ.push_back(expectedPixel(r, c));
         end
   endtask

   task automatic driveInputs();
      bus.fifo_in_dout  = (inQ.size() > 0) ? inQ[0] : 8'd0;
      bus.fifo_in_empty = (inQ.size() == 0) || (bubbles && ($urandom_range(0, 99) < 30));
      bus.fifo_out_full = forceFull;
   endtask

   // One clock: sample at the falling edge, let the FIFOs react just after the rising edge.
   task automatic tick();
      logic rdSeen, wrSeen;
      logic [7:0] dinSeen, expPix;
      @(negedge clock);
      rdSeen  = bus.fifo_in_rd_en;
      wrSeen  = bus.fifo_out_wr_en;
      dinSeen = bus.fifo_out_din;
      if (!reset) begin
         checkOutput("resetRdEn", rdSeen, 0);
         checkOutput("resetWrEn", wrSeen, 0);
         checkOutput("resetDin", dinSeen, 0);
      end
      if (rdSeen) checkOutput("rdWhileEmpty", bus.fifo_in_empty, 0);
      if (bus.fifo_out_full) begin
         checkOutput("stallRdEn", rdSeen, 0);
         checkOutput("stallWrEn", wrSeen, 0);
      end
      if (wrSeen) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", wrSeen, 0);
         end else begin
            expPix = expQ.pop_front();
            checkOutput($sformatf("pixel%0d", wrTotal), dinSeen, expPix);
         end
         if (rdTotal < N * (wrTotal / N + 1)) checkOutput("wrWithoutPop", rdSeen, 1);
         if (wrTotal == 0) firstWrCycle = cycle;
         if (wrTotal == N-1) lastWrF1Cycle = cycle;
         wrTotal++;
      end
      if (rdSeen) begin
         if (rdTotal == W+1) sixthRdCycle = cycle;
         if (rdTotal == N) firstRdF2Cycle = cycle;
      end
      @(posedge clock);
      #1;
      if (rdSeen) begin
         if (inQ.size() > 0) void'(inQ.pop_front());
         rdTotal++;
      end
      cycle++;
      driveInputs();
   endtask

   task automatic newScenario();
      rdTotal = 0;
      wrTotal = 0;
      firstWrCycle = -1;
      sixthRdCycle = -1;
      lastWrF1Cycle = -1;
      firstRdF2Cycle = -1;
   endtask

   task automatic runUntilDone(input string tag, input int expectWrites);
      int guard = 0;
      int startWr = wrTotal;
      while ((expQ.size() > 0 || inQ.size() > 0) && guard < 400) begin
         tick();
         guard++;
      end
      repeat (4) tick();
      checkOutput({tag, "_pending"}, expQ.size(), 0);
      checkOutput({tag, "_writes"}, wrTotal - startWr, expectWrites);
   endtask

   task automatic resetDut();
      reset = 1'b0;
      inQ.delete();
      expQ.delete();
      forceFull = 0;
      bubbles = 0;
      driveInputs();
      repeat (2) tick();
      reset = 1'b1;
      newScenario();
   endtask

   task automatic fillColumns(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
      for (int r = 0; r < H; r++) begin
         img[r*W + 0] = c0;
         img[r*W + 1] = c1;
         img[r*W + 2] = c2;
         img[r*W + 3] = c3;
      end
   endtask

   task automatic fillRandom();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int guard;
      driveInputs();

      $display("[TB] reset");
      resetDut();

      $display("[TB] constant image");
      fillColumns(100, 100, 100, 100);
      applyStimulus();
      driveInputs();
      runUntilDone("constant", N);
      checkOutput("firstWrLatency", firstWrCycle, sixthRdCycle + 1);

      $display("[TB] vertical edge");
      newScenario();
      fillColumns(0, 0, 40, 40);
      applyStimulus();
      driveInputs();
      runUntilDone("vedge", N);

      $display("[TB] saturation");
      newScenario();
      fillColumns(0, 0, 255, 255);
      applyStimulus();
      driveInputs();
      runUntilDone("saturate", N);

      $display("[TB] back-pressure");
      newScenario();
      fillRandom();
      applyStimulus();
      driveInputs();
      guard = 0;
      while (wrTotal < 5 && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput("stallReached", wrTotal, 5);
      forceFull = 1;
      driveInputs();
      repeat (5) tick();
      checkOutput("stallHeldWrites", wrTotal, 5);
      forceFull = 0;
      driveInputs();
      runUntilDone("backpressure", N - 5);

      $display("[TB] input bubbles");
      newScenario();
      fillRandom();
      bubbles = 1;
      applyStimulus();
      driveInputs();
      runUntilDone("bubbles", N);
      bubbles = 0;

      $display("[TB] mid-frame reset then two frames");
      newScenario();
      fillRandom();
      applyStimulus();
      driveInputs();
      guard = 0;
      while (rdTotal < 9 && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput("abortPops", rdTotal, 9);
      resetDut();
      fillRandom();
      applyStimulus();
      fillColumns(0, 0, 40, 40);
      applyStimulus();
      driveInputs();
      runUntilDone("twoFrames", 2 * N);
      checkOutput("frame2FirstPop", firstRdF2Cycle, lastWrF1Cycle + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
